// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bus: the arbiter drives the request side (master),
// the memory returns read data and a single-cycle acknowledge (slave).
interface mem_port_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_adr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_adr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_adr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (I)
// and load/store (D); each access is latched, held until ack or timeout.
module mem_port_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_req,
    input  logic [WIDTH-1:0]       i_adr,
    output logic                   i_gnt,
    output logic                   i_done,
    output logic [WIDTH-1:0]       i_rdata,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [WIDTH-1:0]       d_adr,
    input  logic [WIDTH-1:0]       d_wdata,
    output logic                   d_gnt,
    output logic                   d_done,
    output logic [WIDTH-1:0]       d_rdata,
    mem_port_arbiter_if.master     mem,
    output logic                   adr_src,
    output logic                   err
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic             last_d_q, last_d_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             adr_src_q, adr_src_d;
    logic [WIDTH-1:0] i_adr_q, i_adr_d;
    logic [WIDTH-1:0] d_adr_q, d_adr_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic             i_done_q, i_done_d;
    logic             d_done_q, d_done_d;
    logic             err_q, err_d;

    logic can_grant, pick_i, pick_d, finish;

    // No grant while a done pulse is out, so completion always precedes the next grant.
    assign can_grant = (state_q == IDLE) && !i_done_q && !d_done_q && !reset;
    assign pick_i    = i_req && (!d_req || last_d_q);
    assign pick_d    = d_req && !pick_i;
    assign i_gnt     = can_grant && pick_i;
    assign d_gnt     = can_grant && pick_d;
    assign finish    = mem.mem_ack || (cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        cnt_d     = cnt_q;
        adr_src_d = adr_src_q;
        i_adr_d   = i_adr_q;
        d_adr_d   = d_adr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_gnt) begin
                    i_adr_d   = i_adr;
                    we_d      = 1'b0;
                    adr_src_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = BUSY_I;
                end else if (d_gnt) begin
                    d_adr_d   = d_adr;
                    we_d      = d_we;
                    wdata_d   = d_wdata;
                    adr_src_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (finish) begin
                    // An ack arriving on the final allowed cycle still counts as success.
                    err_d    = !mem.mem_ack;
                    last_d_d = (state_q == BUSY_D);
                    state_d  = IDLE;
                    if (state_q == BUSY_D) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = mem.mem_ack ? mem.mem_rdata : '0;
                    end else begin
                        i_done_d  = 1'b1;
                        i_rdata_d = mem.mem_ack ? mem.mem_rdata : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b1;
            cnt_q     <= '0;
            adr_src_q <= 1'b0;
            i_adr_q   <= '0;
            d_adr_q   <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            cnt_q     <= cnt_d;
            adr_src_q <= adr_src_d;
            i_adr_q   <= i_adr_d;
            d_adr_q   <= d_adr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            err_q     <= err_d;
        end
    end

    assign mem.mem_req   = (state_q != IDLE);
    assign mem.mem_we    = (state_q == BUSY_D) && we_q;
    assign mem.mem_adr   = adr_src_q ? d_adr_q : i_adr_q;
    assign mem.mem_wdata = wdata_q;
    assign adr_src       = adr_src_q;
    assign i_rdata       = i_rdata_q;
    assign d_rdata       = d_rdata_q;
    assign i_done        = i_done_q;
    assign d_done        = d_done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a TIMEOUT=16 instance for the main
// scenarios and a TIMEOUT=4 instance for the abort path, sharing requester inputs.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_adr, d_adr, d_wdata;
    logic        i_gnt, i_done, d_gnt, d_done, adr_src, err;
    logic [31:0] i_rdata, d_rdata;
    logic        t_i_gnt, t_i_done, t_d_gnt, t_d_done, t_adr_src, t_err;
    logic [31:0] t_i_rdata, t_d_rdata;
    int          checks = 0;
    int          errors = 0;

    mem_port_arbiter_if #(.WIDTH(32)) mif ();
    mem_port_arbiter_if #(.WIDTH(32)) tif ();

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_adr(i_adr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem(mif), .adr_src(adr_src), .err(err)
    );

    mem_port_arbiter #(.WIDTH(32), .TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_adr(i_adr), .i_gnt(t_i_gnt), .i_done(t_i_done), .i_rdata(t_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_gnt(t_d_gnt), .d_done(t_d_done), .d_rdata(t_d_rdata),
        .mem(tif), .adr_src(t_adr_src), .err(t_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_adr = '0; d_adr = '0; d_wdata = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        tif.mem_ack = 1'b0; tif.mem_rdata = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] o;
        do_reset();
        #1;
        o = {i_gnt, d_gnt, i_done, d_done, err, adr_src, mif.mem_req, mif.mem_we,
             |mif.mem_adr, |i_rdata, |d_rdata};
        checks++;
        if (o !== 11'd0) begin
            errors++; $display("FAIL reset_outputs: got %b expected all 0", o);
        end
    endtask

    task automatic test_idle_ack();
        do_reset();
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF;
        step();
        step();
        #1;
        checks++;
        if ({mif.mem_req, i_done, d_done, err, |i_rdata, |d_rdata} !== 6'd0) begin
            errors++; $display("FAIL idle_ack: req/done/err/rdata not all 0 (req=%b idone=%b ddone=%b)",
                               mif.mem_req, i_done, d_done);
        end
        mif.mem_ack = 1'b0;
    endtask

    task automatic test_single_fetch();
        do_reset();
        i_req = 1'b1; i_adr = 32'h0000_0010;
        #1;
        checks++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            errors++; $display("FAIL fetch_gnt: got %b expected 10", {i_gnt, d_gnt});
        end
        step(); #1;
        checks++;
        if ({mif.mem_req, mif.mem_we, adr_src} !== 3'b100 || mif.mem_adr !== 32'h10) begin
            errors++; $display("FAIL fetch_busy: req/we/src=%b adr=%h expected 100 adr=10",
                               {mif.mem_req, mif.mem_we, adr_src}, mif.mem_adr);
        end
        step();
        step();
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0010_0093;
        step();
        mif.mem_ack = 1'b0;
        #1;
        checks++;
        if ({i_done, i_gnt, d_done, d_gnt, err} !== 5'b10000 || i_rdata !== 32'h0010_0093) begin
            errors++; $display("FAIL fetch_done: flags=%b rdata=%h expected 10000 rdata=00100093",
                               {i_done, i_gnt, d_done, d_gnt, err}, i_rdata);
        end
        i_req = 1'b0;
        step(); #1;
        checks++;
        if ({i_done, mif.mem_req, adr_src} !== 3'b000 || i_rdata !== 32'h0010_0093 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL fetch_after: done/req/src=%b irdata=%h drdata=%h",
                               {i_done, mif.mem_req, adr_src}, i_rdata, d_rdata);
        end
    endtask

    task automatic test_store();
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_adr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            errors++; $display("FAIL store_gnt: got %b expected 01", {i_gnt, d_gnt});
        end
        step();
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0;
        #1;
        checks++;
        if ({mif.mem_req, mif.mem_we, adr_src} !== 3'b111 || mif.mem_adr !== 32'h100 ||
            mif.mem_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL store_busy: req/we/src=%b adr=%h wdata=%h expected 111 100 deadbeef",
                               {mif.mem_req, mif.mem_we, adr_src}, mif.mem_adr, mif.mem_wdata);
        end
        step();
        mif.mem_ack = 1'b0;
        #1;
        checks++;
        if ({d_done, err, i_done} !== 3'b100) begin
            errors++; $display("FAIL store_done: done/err/idone=%b expected 100", {d_done, err, i_done});
        end
        d_req = 1'b0;
        step(); #1;
        checks++;
        if ({d_done, mif.mem_we, adr_src} !== 3'b001) begin
            errors++; $display("FAIL store_after: done/we/src=%b expected 001", {d_done, mif.mem_we, adr_src});
        end
    endtask

    task automatic test_contention();
        logic exp_d;
        do_reset();
        i_req = 1'b1; i_adr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_adr = 32'h80;
        for (int r = 0; r < 4; r++) begin
            exp_d = r[0];
            #1;
            checks++;
            if ({i_gnt, d_gnt} !== (exp_d ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL rr_gnt%0d: got %b expected %b", r, {i_gnt, d_gnt},
                                   exp_d ? 2'b01 : 2'b10);
            end
            step(); #1;
            checks++;
            if (mif.mem_adr !== (exp_d ? 32'h80 : 32'h40) || adr_src !== exp_d) begin
                errors++; $display("FAIL rr_adr%0d: adr=%h src=%b", r, mif.mem_adr, adr_src);
            end
            step();
            mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1000 + r;
            step();
            mif.mem_ack = 1'b0;
            #1;
            checks++;
            if ({i_done, d_done, i_gnt, d_gnt} !== (exp_d ? 4'b0100 : 4'b1000) ||
                (exp_d ? d_rdata : i_rdata) !== 32'h1000 + r) begin
                errors++; $display("FAIL rr_done%0d: done/gnt=%b irdata=%h drdata=%h",
                                   r, {i_done, d_done, i_gnt, d_gnt}, i_rdata, d_rdata);
            end
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_stability();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_adr = 32'h100;
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++; $display("FAIL stab_gnt: got %b expected 1", d_gnt);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            d_adr = 32'h200;
            if (k == 2) d_req = 1'b0;
            #1;
            checks++;
            if (mif.mem_adr !== 32'h100 || mif.mem_req !== 1'b1 || d_done !== 1'b0) begin
                errors++; $display("FAIL stab_busy%0d: adr=%h req=%b done=%b expected 100 1 0",
                                   k, mif.mem_adr, mif.mem_req, d_done);
            end
        end
        step();
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hCAFE_F00D;
        step();
        mif.mem_ack = 1'b0;
        #1;
        checks++;
        if ({d_done, err} !== 2'b10 || d_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL stab_done: done/err=%b rdata=%h expected 10 cafef00d",
                               {d_done, err}, d_rdata);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        i_req = 1'b1; i_adr = 32'h44;
        step();
        tif.mem_ack = 1'b1; tif.mem_rdata = 32'h0000_ABCD;
        step();
        tif.mem_ack = 1'b0; tif.mem_rdata = 32'h0;
        #1;
        checks++;
        if (t_i_done !== 1'b1 || t_i_rdata !== 32'h0000_ABCD) begin
            errors++; $display("FAIL to_prefetch: done=%b rdata=%h expected 1 0000abcd", t_i_done, t_i_rdata);
        end
        step(); #1;
        checks++;
        if (t_i_gnt !== 1'b1) begin
            errors++; $display("FAIL to_gnt: got %b expected 1", t_i_gnt);
        end
        for (int k = 1; k <= 4; k++) begin
            step(); #1;
            checks++;
            if (tif.mem_req !== 1'b1 || t_err !== 1'b0 || t_i_done !== 1'b0) begin
                errors++; $display("FAIL to_busy%0d: req=%b err=%b done=%b expected 1 0 0",
                                   k, tif.mem_req, t_err, t_i_done);
            end
        end
        step();
        i_req = 1'b0; d_req = 1'b1; d_adr = 32'h300;
        #1;
        checks++;
        if ({t_err, t_i_done, tif.mem_req, t_d_gnt} !== 4'b1100 || t_i_rdata !== 32'h0) begin
            errors++; $display("FAIL to_abort: err/done/req/dgnt=%b rdata=%h expected 1100 0",
                               {t_err, t_i_done, tif.mem_req, t_d_gnt}, t_i_rdata);
        end
        step(); #1;
        checks++;
        if ({t_d_gnt, t_err} !== 2'b10) begin
            errors++; $display("FAIL to_next_gnt: dgnt/err=%b expected 10", {t_d_gnt, t_err});
        end
        d_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_req = 1'b1; i_adr = 32'h20;
        step();
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1;
        step();
        mif.mem_ack = 1'b0; i_req = 1'b0;
        step();
        d_req = 1'b1; d_we = 1'b1; d_adr = 32'h100; d_wdata = 32'h55;
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++; $display("FAIL rm_gnt: got %b expected 1", d_gnt);
        end
        step();
        step();
        reset = 1'b1; mif.mem_ack = 1'b1; mif.mem_rdata = 32'h77;
        step();
        reset = 1'b0; mif.mem_ack = 1'b0; d_req = 1'b0;
        #1;
        checks++;
        if ({d_done, i_done, err, adr_src, mif.mem_req, mif.mem_we} !== 6'd0 ||
            mif.mem_adr !== 32'h0 || mif.mem_wdata !== 32'h0 || d_rdata !== 32'h0 || i_rdata !== 32'h0) begin
            errors++; $display("FAIL rm_cleared: flags=%b adr=%h wdata=%h drdata=%h irdata=%h",
                               {d_done, i_done, err, adr_src, mif.mem_req, mif.mem_we},
                               mif.mem_adr, mif.mem_wdata, d_rdata, i_rdata);
        end
        i_req = 1'b1; d_req = 1'b1;
        #1;
        checks++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            errors++; $display("FAIL rm_tie: got %b expected 10", {i_gnt, d_gnt});
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_ack();
        test_single_fetch();
        test_store();
        test_contention();
        test_stability();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
